// File: rtl/note_player_if.sv
`timescale 1ns/1ps
// note_player_if
// Bundles the sequencer <-> note_player signals.
//   Freq_in     : tone half-period in clock cycles (0 = silence)
//   Temp_in     : note length in clock cycles (0 is treated as 1)
//   Disparo_in  : sequencer trigger, only looked at in IDLE
//   Play_in     : 1 = run, 0 = pause
//   Stop_in     : abort to IDLE, highest priority
//   Audio_out   : registered square-wave audio
//   Duracao_out : registered active-low note-done flag
// master = sequencer side, slave = note_player side.
interface note_player_if #(
  parameter int unsigned WIDTH = 28
);
  logic [WIDTH-1:0] Freq_in;
  logic [WIDTH-1:0] Temp_in;
  logic             Disparo_in;
  logic             Play_in;
  logic             Stop_in;
  logic             Audio_out;
  logic             Duracao_out;

  modport master (
    output Freq_in, Temp_in, Disparo_in, Play_in, Stop_in,
    input  Audio_out, Duracao_out
  );

  modport slave (
    input  Freq_in, Temp_in, Disparo_in, Play_in, Stop_in,
    output Audio_out, Duracao_out
  );
endinterface

// File: rtl/note_player.sv
`timescale 1ns/1ps
// note_player
// Tone and duration engine driven by the melody sequencer. Latches a note's
// half-period and length, produces a square wave for that many cycles (with
// an optional silent tail), then pulls Duracao low until the sequencer is
// running so it can advance exactly one step per note.
// Ports:
//   Clk_in   : system clock
//   Rst_n_in : asynchronous active-low reset
//   bus      : note_player_if slave (Freq/Temp/Disparo/Play/Stop in,
//              Audio/Duracao out)
module note_player #(
  parameter int unsigned WIDTH      = 28,
  parameter int unsigned GAP_CYCLES = 2500000
) (
  input  logic            Clk_in,
  input  logic            Rst_n_in,
  note_player_if.slave    bus
);

  localparam logic [WIDTH-1:0] W_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] GAP_W  = WIDTH'(GAP_CYCLES);
  localparam bit               GAP_EN = (GAP_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_END
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_freq,     w_freq;
  logic [WIDTH-1:0] r_temp,     w_temp;
  logic [WIDTH-1:0] r_dur_cnt,  w_dur_cnt;
  logic [WIDTH-1:0] r_tone_cnt, w_tone_cnt;
  logic             r_phase,    w_phase;
  logic             r_audio,    w_audio;
  logic             r_duracao_n, w_duracao_n;
  logic             w_gap;

  always_ff @(posedge Clk_in or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      r_state     <= S_IDLE;
      r_freq      <= '0;
      r_temp      <= '0;
      r_dur_cnt   <= '0;
      r_tone_cnt  <= '0;
      r_phase     <= 1'b0;
      r_audio     <= 1'b0;
      r_duracao_n <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_freq      <= w_freq;
      r_temp      <= w_temp;
      r_dur_cnt   <= w_dur_cnt;
      r_tone_cnt  <= w_tone_cnt;
      r_phase     <= w_phase;
      r_audio     <= w_audio;
      r_duracao_n <= w_duracao_n;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_freq     = r_freq;
    w_temp     = r_temp;
    w_dur_cnt  = r_dur_cnt;
    w_tone_cnt = r_tone_cnt;
    w_phase    = r_phase;

    if (bus.Stop_in) begin
      w_next     = S_IDLE;
      w_freq     = '0;
      w_temp     = '0;
      w_dur_cnt  = '0;
      w_tone_cnt = '0;
      w_phase    = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.Play_in && bus.Disparo_in) begin
            w_next = S_LOAD;
          end
        end
        S_LOAD: begin
          w_freq     = bus.Freq_in;
          w_temp     = (bus.Temp_in == '0) ? W_ONE : bus.Temp_in;
          w_dur_cnt  = '0;
          w_tone_cnt = '0;
          w_phase    = 1'b0;
          w_next     = S_PLAY;
        end
        S_PLAY: begin
          if (bus.Play_in) begin
            w_dur_cnt = r_dur_cnt + W_ONE;
            if (r_freq != '0) begin
              if (r_tone_cnt == r_freq - W_ONE) begin
                w_tone_cnt = '0;
                w_phase    = ~r_phase;
              end else begin
                w_tone_cnt = r_tone_cnt + W_ONE;
              end
            end
            if (r_dur_cnt == r_temp - W_ONE) begin
              w_next = S_END;
            end
          end else begin
            // Pause: keep remaining duration, restart tone from low phase.
            w_tone_cnt = '0;
            w_phase    = 1'b0;
          end
        end
        S_END: begin
          if (bus.Play_in) begin
            w_next = S_LOAD;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Outputs are registered, so they are computed from the values the
  // counters will hold in the next cycle.
  always_comb begin
    w_gap       = GAP_EN && (w_temp > GAP_W) && (w_dur_cnt >= w_temp - GAP_W);
    w_audio     = (w_next == S_PLAY) && w_phase && (w_freq != '0) && !w_gap;
    w_duracao_n = (w_next != S_END);
  end

  assign bus.Audio_out   = r_audio;
  assign bus.Duracao_out = r_duracao_n;

endmodule

// File: tb/tb_note_player.sv
`timescale 1ns/1ps
module tb_note_player;

  localparam int unsigned W = 28;
  localparam int MI = 0;
  localparam int ML = 1;
  localparam int MP = 2;
  localparam int ME = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  note_player_if #(.WIDTH(W)) bus0 ();
  note_player_if #(.WIDTH(W)) bus2 ();

  note_player #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
    .Clk_in(clk), .Rst_n_in(rst_n), .bus(bus0)
  );
  note_player #(.WIDTH(W), .GAP_CYCLES(2)) dut2 (
    .Clk_in(clk), .Rst_n_in(rst_n), .bus(bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Note-level reference: which phase of the note we are in, how many
  // cycles have been played, and how long the tone has run uninterrupted.
  typedef struct {
    int     mode;
    longint freq;
    longint temp;
    longint el;
    longint run;
  } model_t;

  model_t m;

  function automatic model_t mstep(model_t s, logic play, logic disp, logic stop,
                                   logic [W-1:0] f, logic [W-1:0] t);
    model_t n;
    n = s;
    if (stop) begin
      n.mode = MI; n.freq = 0; n.temp = 0; n.el = 0; n.run = 0;
    end else begin
      case (s.mode)
        MI: if (play && disp) n.mode = ML;
        ML: begin
          n.freq = longint'(f);
          n.temp = (t == '0) ? 1 : longint'(t);
          n.el   = 0;
          n.run  = 0;
          n.mode = MP;
        end
        MP: begin
          if (play) begin
            n.el  = s.el + 1;
            n.run = s.run + 1;
            if (n.el == s.temp) n.mode = ME;
          end else begin
            n.run = 0;
          end
        end
        default: if (play) n.mode = ML;
      endcase
    end
    return n;
  endfunction

  function automatic logic exp_audio(model_t s, longint gap);
    if (s.mode != MP || s.freq == 0) return 1'b0;
    if (gap > 0 && s.temp > gap && s.el >= s.temp - gap) return 1'b0;
    return ((s.run / s.freq) % 2) == 1;
  endfunction

  function automatic logic exp_dur(model_t s);
    return s.mode != ME;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{MI, 0, 0, 0, 0};
    else m <= mstep(m, bus0.Play_in, bus0.Disparo_in, bus0.Stop_in,
                    bus0.Freq_in, bus0.Temp_in);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("g0_audio",   bus0.Audio_out,   exp_audio(m, 0));
      check("g0_duracao", bus0.Duracao_out, exp_dur(m));
      check("g2_audio",   bus2.Audio_out,   exp_audio(m, 2));
      check("g2_duracao", bus2.Duracao_out, exp_dur(m));
    end
  end

  logic ra0 [0:63];
  logic rd0 [0:63];
  logic ra2 [0:63];
  logic rd2 [0:63];

  task automatic drive(input logic play, input logic disp, input logic stop,
                       input int f, input int t);
    bus0.Play_in = play; bus0.Disparo_in = disp; bus0.Stop_in = stop;
    bus0.Freq_in = W'(f); bus0.Temp_in = W'(t);
    bus2.Play_in = play; bus2.Disparo_in = disp; bus2.Stop_in = stop;
    bus2.Freq_in = W'(f); bus2.Temp_in = W'(t);
  endtask

  // Inputs given here are sampled by the edge that starts cycle c.
  task automatic step(input int c, input logic play, input logic disp,
                      input logic stop, input int f, input int t);
    drive(play, disp, stop, f, t);
    @(posedge clk);
    @(negedge clk);
    ra0[c] = bus0.Audio_out;
    rd0[c] = bus0.Duracao_out;
    ra2[c] = bus2.Audio_out;
    rd2[c] = bus2.Duracao_out;
  endtask

  task automatic go_idle();
    step(63, 1'b0, 1'b0, 1'b1, 0, 0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_audio",   bus0.Audio_out,   1'b0);
    check("reset_duracao", bus0.Duracao_out, 1'b1);
    rst_n = 1'b1;

    // Tone, no gap
    for (int c = 0; c < 30; c++) step(c, 1'b1, 1'b1, 1'b0, 3, 20);
    check("tone_c3",  ra0[3],  1'b0);
    check("tone_c4",  ra0[4],  1'b1);
    check("tone_c6",  ra0[6],  1'b1);
    check("tone_c7",  ra0[7],  1'b0);
    check("tone_c10", ra0[10], 1'b1);
    check("tone_c20", ra0[20], 1'b0);
    check("tone_d20", rd0[20], 1'b1);
    check("tone_d21", rd0[21], 1'b0);
    check("tone_d22", rd0[22], 1'b1);
    check("tone_c25", ra0[25], 1'b0);
    check("tone_c26", ra0[26], 1'b1);
    go_idle();

    // Silence and zero length
    for (int c = 0; c < 8; c++) step(c, 1'b1, 1'b1, 1'b0, 0, 5);
    check("sil_a3", ra0[3], 1'b0);
    check("sil_d5", rd0[5], 1'b1);
    check("sil_d6", rd0[6], 1'b0);
    go_idle();
    for (int c = 0; c < 4; c++) step(c, 1'b1, 1'b1, 1'b0, 0, 0);
    check("t0_d1", rd0[1], 1'b1);
    check("t0_d2", rd0[2], 1'b0);
    go_idle();

    // Silent tail
    for (int c = 0; c < 8; c++) step(c, 1'b1, 1'b1, 1'b0, 1, 6);
    check("gap_c1", ra2[1], 1'b0);
    check("gap_c2", ra2[2], 1'b1);
    check("gap_c4", ra2[4], 1'b1);
    check("gap_c5", ra2[5], 1'b0);
    check("gap_c6", ra2[6], 1'b0);
    check("nogap_c6", ra0[6], 1'b1);
    check("gap_d7", rd2[7], 1'b0);
    go_idle();
    for (int c = 0; c < 4; c++) step(c, 1'b1, 1'b1, 1'b0, 1, 2);
    check("gap_t2_c2", ra2[2], 1'b1);
    go_idle();

    // Pause mid-note, then pause while END is showing
    for (int c = 0; c < 40; c++)
      step(c, !((c >= 6 && c <= 15) || (c >= 32 && c <= 36)), 1'b1, 1'b0, 3, 20);
    check("pause_c5",  ra0[5],  1'b1);
    check("pause_c6",  ra0[6],  1'b0);
    check("pause_c15", ra0[15], 1'b0);
    check("pause_c17", ra0[17], 1'b0);
    check("pause_c18", ra0[18], 1'b1);
    check("pause_d30", rd0[30], 1'b1);
    check("pause_d31", rd0[31], 1'b0);
    check("pause_d36", rd0[36], 1'b0);
    check("pause_d37", rd0[37], 1'b1);
    go_idle();

    // Stop mid-note: no END pulse afterwards
    for (int c = 0; c < 30; c++) step(c, 1'b1, c < 9, c == 9, 3, 20);
    check("stop_a9", ra0[9], 1'b0);
    for (int c = 9; c < 30; c++) check("stop_no_end", rd0[c], 1'b1);
    // Stop on the edge that would enter END
    for (int c = 0; c < 8; c++) step(c, 1'b1, c == 0, c == 4, 3, 3);
    check("stop_end_d4", rd0[4], 1'b1);
    // Stop while END is showing
    for (int c = 0; c < 8; c++) step(c, c < 5, c == 0, c == 6, 3, 3);
    check("stopin_end_d5", rd0[5], 1'b0);
    check("stopin_end_d6", rd0[6], 1'b1);

    // Asynchronous reset mid-tone and while END is held
    for (int c = 0; c < 6; c++) step(c, 1'b1, 1'b1, 1'b0, 3, 20);
    check("rst_pre_a5", ra0[5], 1'b1);
    #1 rst_n = 1'b0;
    #1 check("rst_async_audio", bus0.Audio_out, 1'b0);
    check("rst_async_dur", bus0.Duracao_out, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 6; c++) step(c, 1'b1, 1'b0, 1'b0, 3, 20);
    check("rst_idle_d5", rd0[5], 1'b1);
    for (int c = 0; c < 5; c++) step(c, c < 3, 1'b1, 1'b0, 3, 1);
    check("rst_end_d4", rd0[4], 1'b0);
    #1 rst_n = 1'b0;
    #1 check("rst_end_async_dur", bus0.Duracao_out, 1'b1);
    @(negedge clk) rst_n = 1'b1;

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 49) == 0,
            int'($urandom_range(0, 5)), int'($urandom_range(0, 12)));
      @(posedge clk);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_player.md
# note_player

Tone and duration engine at the far end of the melody sequencer interface. It takes the sequencer's half-period overflow (`Freq`), note-duration overflow (`Temp`) and trigger (`Disparo`), and generates the square-wave audio output. It signals each note's completion back to the sequencer on the active-low `Duracao` line, which advances the sequencer by exactly one state per note.

## Interface
- `WIDTH`, default 28: width of the frequency and duration overflow values and of the internal counters.
- `GAP_CYCLES`, default 2500000: number of forced-silent cycles at the tail of every note (50 ms at 50 MHz). 0 disables the gap.

Ports:
- `Clk_in`  input  1  system clock (50 MHz). This is the only clock.
- `Rst_n_in`  input  1  reset, asynchronous, active-low.
- `Freq_in`  input  WIDTH  half-period of the tone, in clock cycles. 0 means silence.
- `Temp_in`  input  WIDTH  note length, in clock cycles. 0 is treated as 1.
- `Disparo_in`  input  1  sequencer trigger. Must be 1 to leave IDLE.
- `Play_in`  input  1  1 = run, 0 = pause.
- `Stop_in`  input  1  abort and return to IDLE. Highest priority.
- `Audio_out`  output  1  square-wave audio. Registered.
- `Duracao_out`  output  1  active-low note-done flag, fed to the sequencer's `Duracao`. Registered.

## Operation
- The state machine has four states: IDLE, LOAD, PLAY, END.
- Registers: `freq_r`, `temp_r`, `dur_cnt`, `tone_cnt`, tone phase bit.
- IDLE: `Audio_out`=0, `Duracao_out`=1.
  - Moves to LOAD when `Play_in`=1, `Disparo_in`=1 and `Stop_in`=0.
- LOAD: lasts exactly 1 cycle.
  - Latches `freq_r`←`Freq_in`.
  - Latches `temp_r`←`Temp_in`, or 1 if `Temp_in`=0.
  - Clears `dur_cnt`, `tone_cnt` and the phase bit.
  - `Audio_out`=0. Next state is PLAY.
- PLAY, on each cycle with `Play_in`=1:
  - `dur_cnt`+1.
  - If `freq_r`≠0: `tone_cnt`+1. When `tone_cnt`=`freq_r`−1, `tone_cnt`←0 and the phase toggles.
  - `Audio_out` = phase, except it is forced to 0 when `freq_r`=0, or when `GAP_CYCLES`>0, `temp_r`>`GAP_CYCLES` and `dur_cnt` ≥ `temp_r`−`GAP_CYCLES`.
  - When `dur_cnt`=`temp_r`−1, the next state is END.
- PLAY with `Play_in`=0 (pause):
  - `dur_cnt` is held; `tone_cnt` and the phase are cleared.
  - `Audio_out`=0, `Duracao_out`=1.
  - On resume, the tone restarts from the low phase. The remaining duration is preserved.
- END: `Duracao_out`=0, `Audio_out`=0.
  - Moves to LOAD on the first cycle with `Play_in`=1; otherwise stays in END.
  - `Duracao_out` therefore remains low until the sequencer can sample `Duracao`=0 together with `Play`=1. The sequencer advances on the same edge that this block leaves END.
- `Stop_in`=1 in any state: the next edge goes to IDLE, with `Audio_out`=0, `Duracao_out`=1 and all counters cleared.
- Counters are WIDTH bits wide. Comparisons are unsigned. `temp_r`−1 never underflows because `temp_r` ≥ 1.

## Timing
- Reset (`Rst_n_in`=0, asynchronous): state=IDLE, `Audio_out`=0, `Duracao_out`=1, all registers 0.
- Release of `Rst_n_in` takes effect on the first `Clk_in` rising edge.
- The IDLE→LOAD decision is made on the edge where the start conditions are sampled.
- The note cycle is LOAD (1) + PLAY (`temp_r`) + END (≥1). That is `temp_r`+2 cycles when `Play_in` stays high.
- The sequencer updates its state on the edge that ends END. The new `Freq_in`/`Temp_in` therefore become valid during the following LOAD cycle and are latched at the end of it.
- Tone period = 2·`freq_r` cycles. The first toggle is `freq_r` cycles after entering PLAY.
- `Audio_out` and `Duracao_out` both change only on `Clk_in` edges, except on asynchronous reset.
- `Stop_in` and END occurring in the same cycle: `Stop_in` wins, the next state is IDLE and `Duracao_out` returns to 1.
- `Disparo_in` is ignored outside IDLE.

## Test plan
- Reset: assert `Rst_n_in`=0 mid-note with `Freq_in`=3 → `Audio_out`=0 and `Duracao_out`=1 immediately; the block stays in IDLE until `Play_in` and `Disparo_in` are both 1.
- Tone: `GAP_CYCLES`=0, `Freq_in`=3, `Temp_in`=20, `Play_in`=`Disparo_in`=1, with LOAD at cycle 0 → `Audio_out` rises at cycle 4 and toggles every 3 cycles; `Duracao_out`=0 only in cycle 21; the next LOAD is in cycle 22.
- Silence: `Freq_in`=0, `Temp_in`=5 → `Audio_out`=0 throughout; the `Duracao_out` low pulse occurs 6 cycles after LOAD. With `Temp_in`=0 → the pulse occurs 2 cycles after LOAD.
- Gap: `GAP_CYCLES`=2, `Freq_in`=1, `Temp_in`=6 → `Audio_out` toggles for `dur_cnt` 0–3 and is 0 for `dur_cnt` 4–5. With `Temp_in`=2 → no gap is applied.
- Pause: `Play_in`=0 for 10 cycles mid-PLAY → `Audio_out`=0 and the END pulse is delayed by exactly 10 cycles. `Play_in`=0 on entering END → `Duracao_out` is held 0 until `Play_in`=1, then LOAD follows on the next edge.
- Stop: `Stop_in`=1 at `dur_cnt`=7 of a `Temp_in`=20 note → the next edge is IDLE with `Audio_out`=0 and `Duracao_out`=1. No END pulse occurs, including when the stop coincides with the END cycle.
